// File: rtl/spi_flash_master.sv
// -----------------------------------------------------------------------------
// spi_flash_master
//
// SPI mode-0 master for the M25P16 serial flash. A host hands over a stream of
// bytes; each transaction lives inside one chip-select window. Bytes go out
// MSB-first on MOSI while MISO is captured in parallel, and every received byte
// is reported with a one-cycle rx_valid pulse. CS setup, CS hold, CS deselect
// spacing and the SCK high/low times are all produced by counters, so the flash
// timing holds by construction.
//
// Ports
//   clk_i          system clock, all registers on its rising edge
//   rst_n_i        synchronous reset, active low
//   byte_valid_i   host offers byte_data_i / byte_last_i
//   byte_data_i    byte to transmit, MSB first
//   byte_last_i    offered byte closes the transaction
//   byte_ready_o   byte is taken on an edge where byte_valid_i is also high
//   rx_valid_o     one-cycle pulse, rx_data_o holds a fresh byte
//   rx_data_o      last received byte, held until the next rx_valid_o
//   busy_o         first accept until the deselect gap has elapsed
//   spi_cs_n_o     flash chip select, active low
//   spi_sck_o      flash serial clock, idles low
//   spi_mosi_o     flash D input
//   spi_miso_i     flash Q output
//   spi_hold_n_o   flash HOLD, kept inactive
// -----------------------------------------------------------------------------
module spi_flash_master #(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    input  logic       byte_last_i,
    output logic       byte_ready_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       spi_cs_n_o,
    output logic       spi_sck_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       spi_hold_n_o
);

    localparam int HW     = $clog2(CLK_DIV + 1);
    localparam int TMAX_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TMAX   = (TMAX_A > CS_IDLE) ? TMAX_A : CS_IDLE;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_DIV);

    typedef enum logic [2:0] {
        ST_IDLE_GAP,
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_NEXT,
        ST_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [HW-1:0] half_q, half_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_q, tx_d;
    logic          last_q, last_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          busy_q, busy_d;
    logic          cs_n_q, cs_n_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          accept;

    assign byte_ready_o = (state_q == ST_IDLE) || (state_q == ST_NEXT);
    assign accept       = byte_valid_i && byte_ready_o;

    assign rx_valid_o   = rx_valid_q;
    assign rx_data_o    = rx_data_q;
    assign busy_o       = busy_q;
    assign spi_cs_n_o   = cs_n_q;
    assign spi_sck_o    = sck_q;
    assign spi_mosi_o   = mosi_q;
    assign spi_hold_n_o = 1'b1;

    // State register. Reset lands in the deselect gap with the full count so
    // the first transaction after reset also sees the minimum CS-high time.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE_GAP;
            tcnt_q     <= TW'(CS_IDLE);
            half_q     <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            last_q     <= 1'b0;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            last_q     <= last_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            cs_n_q     <= cs_n_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
        end
    end

    // Next-state logic. Both counters are loaded with their full length and
    // expire when they reach 1, so a load of N spans exactly N clk cycles.
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        half_d     = half_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        last_d     = last_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        cs_n_d     = cs_n_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;

        case (state_q)
            ST_IDLE_GAP: begin
                if (tcnt_q <= TW'(1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end

            ST_IDLE: begin
                if (accept) begin
                    tx_d    = byte_data_i;
                    last_d  = byte_last_i;
                    cs_n_d  = 1'b0;
                    mosi_d  = byte_data_i[7];
                    busy_d  = 1'b1;
                    tcnt_d  = TW'(CS_SETUP);
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (tcnt_q <= TW'(1)) begin
                    half_d  = HALF_LOAD;
                    bit_d   = 3'd7;
                    state_d = ST_SHIFT;
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end

            // A low half-period then a high half-period per bit. MISO is
            // captured on the rising SCK edge; the falling edge moves MOSI on,
            // except after bit 0 where the byte is handed to the host instead.
            ST_SHIFT: begin
                if (half_q <= HW'(1)) begin
                    half_d = HALF_LOAD;
                    if (!sck_q) begin
                        sck_d   = 1'b1;
                        shreg_d = {shreg_q[6:0], spi_miso_i};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 3'd0) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                            if (last_q) begin
                                tcnt_d  = TW'(CS_HOLD);
                                state_d = ST_HOLD;
                            end else begin
                                state_d = ST_NEXT;
                            end
                        end else begin
                            bit_d  = bit_q - 3'd1;
                            mosi_d = tx_q[bit_q - 3'd1];
                        end
                    end
                end else begin
                    half_d = half_q - HW'(1);
                end
            end

            // Chip select stays asserted while the host takes its time; the
            // next byte starts its first low phase straight away.
            ST_NEXT: begin
                if (accept) begin
                    tx_d    = byte_data_i;
                    last_d  = byte_last_i;
                    mosi_d  = byte_data_i[7];
                    half_d  = HALF_LOAD;
                    bit_d   = 3'd7;
                    state_d = ST_SHIFT;
                end
            end

            ST_HOLD: begin
                if (tcnt_q <= TW'(1)) begin
                    cs_n_d  = 1'b1;
                    tcnt_d  = TW'(CS_IDLE);
                    state_d = ST_IDLE_GAP;
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE_GAP;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_flash_master.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_master
//
// Directed bench for spi_flash_master with default timing parameters. A small
// flash model drives MISO from a per-test response table (advancing one bit per
// SCK fall, restarting on CS fall) and collects the MOSI bytes and every
// rx_valid byte into queues for the scenario tasks to inspect.
// -----------------------------------------------------------------------------
module tb_spi_flash_master;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 3;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       byteValid = 1'b0;
    logic [7:0] byteData = 8'h00;
    logic       byteLast = 1'b0;
    logic       byteReady;
    logic       rxValid;
    logic [7:0] rxData;
    logic       busy;
    logic       spiCsN;
    logic       spiSck;
    logic       spiMosi;
    logic       spiMiso = 1'b0;
    logic       spiHoldN;

    int errors = 0;
    int checks = 0;

    logic [7:0] resp [0:7];
    logic [7:0] rxq [$];
    logic [7:0] mosiq [$];
    int         csRiseCnt = 0;
    int         fallCnt = 0;
    int         riseCnt = 0;
    int         byteIdx;
    logic [7:0] mosiSh = 8'h00;
    logic [7:0] curResp;
    logic       csPrev = 1'b1;
    logic       sckPrev = 1'b0;

    spi_flash_master #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .CS_IDLE (CS_IDLE)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .byte_valid_i(byteValid),
        .byte_data_i (byteData),
        .byte_last_i (byteLast),
        .byte_ready_o(byteReady),
        .rx_valid_o  (rxValid),
        .rx_data_o   (rxData),
        .busy_o      (busy),
        .spi_cs_n_o  (spiCsN),
        .spi_sck_o   (spiSck),
        .spi_mosi_o  (spiMosi),
        .spi_miso_i  (spiMiso),
        .spi_hold_n_o(spiHoldN)
    );

    always #5 clk = ~clk;

    // Flash model, evaluated mid-cycle so every DUT output has settled.
    always @(negedge clk) begin
        if (csPrev === 1'b1 && spiCsN === 1'b0) begin
            fallCnt = 0;
            riseCnt = 0;
        end else if (spiCsN === 1'b0 && sckPrev === 1'b1 && spiSck === 1'b0) begin
            fallCnt = fallCnt + 1;
        end
        if (spiCsN === 1'b0 && sckPrev === 1'b0 && spiSck === 1'b1) begin
            mosiSh  = {mosiSh[6:0], spiMosi};
            riseCnt = riseCnt + 1;
            if (riseCnt % 8 == 0) mosiq.push_back(mosiSh);
        end
        if (csPrev === 1'b0 && spiCsN === 1'b1) csRiseCnt = csRiseCnt + 1;
        if (rxValid === 1'b1) rxq.push_back(rxData);
        csPrev  = spiCsN;
        sckPrev = spiSck;
        byteIdx = fallCnt / 8;
        if (byteIdx > 7) byteIdx = 7;
        curResp = resp[byteIdx];
        spiMiso = curResp[3'(7 - (fallCnt % 8))];
    end

    // Hard time limit so the run always ends even if a wait loop misbehaves.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel(input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input logic [7:0] r3);
        resp[0] = r0; resp[1] = r1; resp[2] = r2; resp[3] = r3;
        for (int i = 4; i < 8; i++) resp[i] = 8'h00;
        rxq.delete();
        mosiq.delete();
        csRiseCnt = 0;
    endtask

    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (byteReady === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic waitBusyLow(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic waitRx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rxq.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic sendByte(input logic [7:0] d, input logic last, output bit ok);
        waitReady(ok);
        byteValid = 1'b1;
        byteData  = d;
        byteLast  = last;
        tick();
        byteValid = 1'b0;
        byteLast  = 1'b0;
    endtask

    // Reset values, then the deselect gap before byte_ready first rises.
    task automatic test_reset();
        int readyAt;
        rstN = 1'b0;
        tick();
        tick();
        checks++;
        if (spiCsN !== 1'b1 || spiSck !== 1'b0 || spiMosi !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pins: cs_n=%b sck=%b mosi=%b expected 1 0 0", spiCsN, spiSck, spiMosi);
        end
        checks++;
        if (rxValid !== 1'b0 || rxData !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_rx: rx_valid=%b rx_data=%h expected 0 00", rxValid, rxData);
        end
        checks++;
        if (busy !== 1'b0 || byteReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: busy=%b byte_ready=%b expected 0 0", busy, byteReady);
        end
        checks++;
        if (spiHoldN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_n: got %b expected 1", spiHoldN);
        end
        rstN = 1'b1;
        readyAt = -1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (readyAt < 0 && byteReady === 1'b1) readyAt = k;
        end
        checks++;
        if (readyAt != CS_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_gap: byte_ready rose after %0d cycles expected %0d", readyAt, CS_IDLE);
        end
    endtask

    // WREN: one byte, full cycle-accurate timeline from the accept edge.
    task automatic test_single_byte();
        bit ok;
        bit csBad;
        int rxCount, rxAt, firstRise, readyAt, busyAt;
        logic [7:0] rxSeen;
        clearModel(8'hA5, 8'h00, 8'h00, 8'h00);
        waitReady(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL single_ready: byte_ready=%b expected 1", byteReady);
        end
        byteValid = 1'b1;
        byteData  = 8'h06;
        byteLast  = 1'b1;
        tick();
        byteValid = 1'b0;
        byteLast  = 1'b0;
        csBad = 1'b0;
        rxCount = 0; rxAt = -1; firstRise = -1; readyAt = -1; busyAt = -1;
        rxSeen = 8'h00;
        for (int k = 0; k <= 40; k++) begin
            if (k <= 35 && spiCsN !== 1'b0) csBad = 1'b1;
            if (k >= 36 && spiCsN !== 1'b1) csBad = 1'b1;
            if (rxValid === 1'b1) begin
                rxCount++;
                rxAt   = k;
                rxSeen = rxData;
            end
            if (firstRise < 0 && spiSck === 1'b1) firstRise = k;
            if (readyAt < 0 && byteReady === 1'b1) readyAt = k;
            if (busyAt < 0 && busy === 1'b0) busyAt = k;
            if (k != 40) tick();
        end
        checks++;
        if (csBad) begin
            errors++;
            $display("[TB] FAIL single_cs: cs_n window wrong, expected low T0..T0+35 high from T0+36");
        end
        checks++;
        if (rxCount != 1 || rxAt != 34) begin
            errors++;
            $display("[TB] FAIL single_rxv: %0d pulses last at T0+%0d expected 1 at T0+34", rxCount, rxAt);
        end
        checks++;
        if (rxSeen !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL single_rxd: got %h expected a5", rxSeen);
        end
        checks++;
        if (firstRise != 4) begin
            errors++;
            $display("[TB] FAIL single_sck: first rise T0+%0d expected T0+4", firstRise);
        end
        checks++;
        if (readyAt != 39 || busyAt != 39) begin
            errors++;
            $display("[TB] FAIL single_end: ready at %0d busy low at %0d expected 39 39", readyAt, busyAt);
        end
        checks++;
        if (mosiq.size() != 1 || mosiq[0] !== 8'h06) begin
            errors++;
            $display("[TB] FAIL single_mosi: %0d bytes first %h expected 1 byte 06",
                     mosiq.size(), (mosiq.size() > 0) ? mosiq[0] : 8'hxx);
        end
    endtask

    // RDID: four bytes in one CS window, ID bytes come back on bytes 2..4.
    task automatic test_rdid();
        bit ok, allOk;
        logic [7:0] txv [0:3];
        logic [7:0] rxv [0:3];
        txv[0] = 8'h9F; txv[1] = 8'h00; txv[2] = 8'h00; txv[3] = 8'h00;
        rxv[0] = 8'h00; rxv[1] = 8'h20; rxv[2] = 8'h20; rxv[3] = 8'h15;
        clearModel(8'h00, 8'h20, 8'h20, 8'h15);
        allOk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sendByte(txv[i], (i == 3), ok);
            if (!ok) allOk = 1'b0;
        end
        waitRx(4, ok);
        if (!ok) allOk = 1'b0;
        checks++;
        if (!allOk) begin
            errors++;
            $display("[TB] FAIL rdid_flow: transfer stalled, %0d of 4 bytes received", rxq.size());
        end
        checks++;
        if (csRiseCnt != 0) begin
            errors++;
            $display("[TB] FAIL rdid_cs: cs_n rose %0d times mid-transaction expected 0", csRiseCnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxq.size() <= i || rxq[i] !== rxv[i] || mosiq.size() <= i || mosiq[i] !== txv[i]) begin
                errors++;
                $display("[TB] FAIL rdid_byte%0d: rx=%h mosi=%h expected rx=%h mosi=%h", i,
                         (rxq.size() > i) ? rxq[i] : 8'hxx, (mosiq.size() > i) ? mosiq[i] : 8'hxx,
                         rxv[i], txv[i]);
            end
        end
        waitBusyLow(ok);
        checks++;
        if (!ok || csRiseCnt != 1) begin
            errors++;
            $display("[TB] FAIL rdid_end: busy=%b cs_n rises=%0d expected 0 1", busy, csRiseCnt);
        end
    endtask

    // READ with a 50-cycle host stall between the 2nd and 3rd byte.
    task automatic test_stall();
        bit ok, allOk, stallBad;
        logic [7:0] txv [0:3];
        logic [7:0] rxv [0:3];
        txv[0] = 8'h03; txv[1] = 8'h12; txv[2] = 8'h34; txv[3] = 8'h56;
        rxv[0] = 8'hC3; rxv[1] = 8'hAA; rxv[2] = 8'h55; rxv[3] = 8'h3C;
        clearModel(8'hC3, 8'hAA, 8'h55, 8'h3C);
        allOk = 1'b1;
        sendByte(txv[0], 1'b0, ok);
        if (!ok) allOk = 1'b0;
        sendByte(txv[1], 1'b0, ok);
        if (!ok) allOk = 1'b0;
        waitRx(2, ok);
        if (!ok) allOk = 1'b0;
        stallBad = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (spiSck !== 1'b0 || spiCsN !== 1'b0 || byteReady !== 1'b1) stallBad = 1'b1;
        end
        checks++;
        if (stallBad) begin
            errors++;
            $display("[TB] FAIL stall_lines: sck=%b cs_n=%b ready=%b during stall expected 0 0 1",
                     spiSck, spiCsN, byteReady);
        end
        sendByte(txv[2], 1'b0, ok);
        if (!ok) allOk = 1'b0;
        sendByte(txv[3], 1'b1, ok);
        if (!ok) allOk = 1'b0;
        waitRx(4, ok);
        if (!ok) allOk = 1'b0;
        checks++;
        if (!allOk || csRiseCnt != 0) begin
            errors++;
            $display("[TB] FAIL stall_flow: ok=%b cs_n rises=%0d expected 1 0", allOk, csRiseCnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxq.size() <= i || rxq[i] !== rxv[i] || mosiq.size() <= i || mosiq[i] !== txv[i]) begin
                errors++;
                $display("[TB] FAIL stall_byte%0d: rx=%h mosi=%h expected rx=%h mosi=%h", i,
                         (rxq.size() > i) ? rxq[i] : 8'hxx, (mosiq.size() > i) ? mosiq[i] : 8'hxx,
                         rxv[i], txv[i]);
            end
        end
        waitBusyLow(ok);
    endtask

    // Two one-byte transactions with byte_valid never dropping in between.
    task automatic test_back_to_back();
        bit ok, readyBad, seenHigh, done;
        int csHighRun, gapLen;
        clearModel(8'h5A, 8'h00, 8'h00, 8'h00);
        waitReady(ok);
        byteValid = 1'b1;
        byteData  = 8'hA1;
        byteLast  = 1'b1;
        tick();
        byteData  = 8'hB2;
        readyBad = 1'b0; seenHigh = 1'b0; done = 1'b0;
        csHighRun = 0; gapLen = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (spiCsN === 1'b1) begin
                seenHigh = 1'b1;
                csHighRun++;
                if (byteReady === 1'b1 && csHighRun <= CS_IDLE) readyBad = 1'b1;
            end else if (seenHigh) begin
                gapLen = csHighRun;
                done   = 1'b1;
                break;
            end
        end
        byteValid = 1'b0;
        byteLast  = 1'b0;
        checks++;
        if (!done || gapLen < CS_IDLE + 1) begin
            errors++;
            $display("[TB] FAIL b2b_gap: cs_n high %0d cycles (done=%b) expected >= %0d", gapLen, done, CS_IDLE + 1);
        end
        checks++;
        if (readyBad) begin
            errors++;
            $display("[TB] FAIL b2b_ready: byte_ready=1 inside deselect gap expected 0");
        end
        waitBusyLow(ok);
        checks++;
        if (!ok || mosiq.size() != 2 || rxq.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: mosi bytes=%0d rx bytes=%0d expected 2 2", mosiq.size(), rxq.size());
        end
        checks++;
        if (mosiq.size() < 2 || mosiq[0] !== 8'hA1 || mosiq[1] !== 8'hB2) begin
            errors++;
            $display("[TB] FAIL b2b_mosi: got %h %h expected a1 b2",
                     (mosiq.size() > 0) ? mosiq[0] : 8'hxx, (mosiq.size() > 1) ? mosiq[1] : 8'hxx);
        end
    endtask

    // One-cycle reset during bit 4 aborts the byte with no rx_valid.
    task automatic test_reset_mid();
        bit ok;
        int readyAt;
        clearModel(8'hFF, 8'h00, 8'h00, 8'h00);
        waitReady(ok);
        byteValid = 1'b1;
        byteData  = 8'hF0;
        byteLast  = 1'b1;
        tick();
        byteValid = 1'b0;
        byteLast  = 1'b0;
        for (int k = 1; k <= 16; k++) tick();
        checks++;
        if (spiSck !== 1'b1 || spiCsN !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_pre: sck=%b cs_n=%b at bit-4 rise expected 1 0", spiSck, spiCsN);
        end
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checks++;
        if (spiCsN !== 1'b1 || spiSck !== 1'b0 || rxValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_pins: cs_n=%b sck=%b rx_valid=%b expected 1 0 0", spiCsN, spiSck, rxValid);
        end
        checks++;
        if (busy !== 1'b0 || byteReady !== 1'b0 || spiMosi !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_flags: busy=%b ready=%b mosi=%b expected 0 0 0", busy, byteReady, spiMosi);
        end
        readyAt = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (readyAt < 0 && byteReady === 1'b1) readyAt = k;
        end
        checks++;
        if (readyAt != CS_IDLE) begin
            errors++;
            $display("[TB] FAIL mid_gap: byte_ready rose after %0d cycles expected %0d", readyAt, CS_IDLE);
        end
        checks++;
        if (rxq.size() != 0) begin
            errors++;
            $display("[TB] FAIL mid_rx: %0d rx_valid pulses for aborted byte expected 0", rxq.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
        $display("[TB] starting spi_flash_master bench");
        test_reset();
        test_single_byte();
        test_rdid();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
